// File: rtl/read_bram_pkg.sv
// Shared constants, FSM encodings and keep helper for the BRAM frame reader.
package read_bram_pkg;

    localparam int WORD_BYTES = 32;
    localparam int WORD_W     = 256;
    localparam int ADDR_W     = 10;
    localparam int SBYTES_W   = 11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Keep mask for the final word; r is the byte count modulo 32.
    function automatic logic [WORD_BYTES-1:0] keep_from_bytes(
        input logic [4:0] r
    );
        if (r == 5'd0) begin
            return '1;
        end
        return (32'd1 << r) - 32'd1;
    endfunction

endpackage

// File: rtl/read_bram_sync_fifo.sv
// Synchronous FIFO; a push on a full FIFO is taken only when a pop
// frees a slot in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push & ~do_pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (do_pop & ~do_push) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/read_bram.sv
// Reads packed frame words back out of BRAM per descriptor and streams
// them as an AXI-stream frame with tkeep/tlast and full backpressure.
module read_bram #(
    parameter int RD_LATENCY = 1,
    parameter int DESC_DEPTH = 4,
    parameter int OUT_DEPTH  = 4,
    parameter int ADDR_W     = 10
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ADDR_W-1:0]                      saddr,
    input  logic [read_bram_pkg::SBYTES_W-1:0]     sbytes,
    input  logic                                   svalid,
    output logic                                   ren,
    output logic [ADDR_W-1:0]                      raddr,
    input  logic [read_bram_pkg::WORD_W-1:0]       rdata,
    output logic [read_bram_pkg::WORD_W-1:0]       m_tdata,
    output logic [read_bram_pkg::WORD_BYTES-1:0]   m_tkeep,
    output logic                                   m_tlast,
    output logic                                   m_tvalid,
    input  logic                                   m_tready,
    output logic                                   done,
    output logic                                   busy,
    output logic                                   desc_overflow
);

    import read_bram_pkg::*;

    localparam int DW = ADDR_W + SBYTES_W;
    localparam int OW = WORD_W + WORD_BYTES + 1;
    localparam int CW = $clog2(OUT_DEPTH) + 2;

    logic                      svalid_q;
    logic                      ovf_q;
    logic [1:0]                state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [6:0]                rem_q, rem_d;
    logic [WORD_BYTES-1:0]     lkeep_q, lkeep_d;

    logic [RD_LATENCY-1:0]     pv_q;
    logic [RD_LATENCY-1:0]     pl_q;
    logic [WORD_BYTES-1:0]     pk_q [RD_LATENCY];

    logic                      desc_push, desc_pop;
    logic                      desc_full, desc_empty;
    logic [DW-1:0]             desc_dout;
    logic [$clog2(DESC_DEPTH):0] desc_cnt;
    logic [ADDR_W-1:0]         d_addr;
    logic [SBYTES_W-1:0]       d_bytes;

    logic                      out_full, out_empty;
    logic [OW-1:0]             out_dout;
    logic [$clog2(OUT_DEPTH):0] out_cnt;

    logic [CW-1:0]             inflight;
    logic                      issue, last_issue, beat_acc;
    logic [WORD_BYTES-1:0]     keep_issue;

    assign desc_push = svalid & ~svalid_q;
    assign desc_pop  = (state_q == IDLE) & ~desc_empty;
    assign {d_addr, d_bytes} = desc_dout;

    sync_fifo #(.W(DW), .DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (desc_push),
        .din_i   ({saddr, sbytes}),
        .pop_i   (desc_pop),
        .dout_o  (desc_dout),
        .full_o  (desc_full),
        .empty_o (desc_empty),
        .count_o (desc_cnt)
    );

    // Credit: reads in flight plus queued beats must fit in the output FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pv_q[i]);
        end
    end

    assign issue      = (state_q == READ) & ~out_full &
                        ((CW'(out_cnt) + inflight) < CW'(OUT_DEPTH));
    assign last_issue = (rem_q == 7'd1);
    assign keep_issue = last_issue ? lkeep_q : '1;
    assign beat_acc   = m_tvalid & m_tready;

    assign ren   = issue;
    assign raddr = addr_q;
    assign done  = (desc_pop & (d_bytes == '0)) |
                   ((state_q == DRAIN) & beat_acc & m_tlast);
    assign busy  = (desc_cnt != '0) | (state_q != IDLE);
    assign desc_overflow = ovf_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        lkeep_d = lkeep_q;
        unique case (state_q)
            IDLE: begin
                if (desc_pop) begin
                    addr_d  = d_addr;
                    rem_d   = 7'(({1'b0, d_bytes} + 12'd31) >> 5);
                    lkeep_d = keep_from_bytes(d_bytes[4:0]);
                    if (d_bytes != '0) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - 7'd1;
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat_acc & m_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            svalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            lkeep_q  <= '0;
        end else begin
            svalid_q <= svalid;
            ovf_q    <= ovf_q | (desc_push & desc_full & ~desc_pop);
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            lkeep_q  <= lkeep_d;
        end
    end

    // Side-band {valid, last, keep} travels alongside each BRAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q <= '0;
            pl_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pk_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue;
            pl_q[0] <= last_issue;
            pk_q[0] <= keep_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
                pk_q[i] <= pk_q[i-1];
            end
        end
    end

    sync_fifo #(.W(OW), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pv_q[RD_LATENCY-1]),
        .din_i   ({pl_q[RD_LATENCY-1], pk_q[RD_LATENCY-1], rdata}),
        .pop_i   (beat_acc),
        .dout_o  (out_dout),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_cnt)
    );

    assign m_tvalid = ~out_empty;
    assign {m_tlast, m_tkeep, m_tdata} = out_empty ? '0 : out_dout;

endmodule

// File: tb/tb_read_bram.sv
// Self-checking bench for read_bram: table-driven frames, hand-written
// corner sequences and a randomized run against a beat-queue model.
module tb_read_bram;

    localparam int RL = 1;
    localparam int OD = 4;

    logic         clk;
    logic         reset;
    logic [9:0]   saddr;
    logic [10:0]  sbytes;
    logic         svalid;
    logic         ren;
    logic [9:0]   raddr;
    logic [255:0] rdata;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic         done;
    logic         busy;
    logic         desc_overflow;

    read_bram #(
        .RD_LATENCY (RL),
        .DESC_DEPTH (4),
        .OUT_DEPTH  (OD),
        .ADDR_W     (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .saddr         (saddr),
        .sbytes        (sbytes),
        .svalid        (svalid),
        .ren           (ren),
        .raddr         (raddr),
        .rdata         (rdata),
        .m_tdata       (m_tdata),
        .m_tkeep       (m_tkeep),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .done          (done),
        .busy          (busy),
        .desc_overflow (desc_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM contents and a read pipe of RL stages
    logic [255:0] mem [1024];
    logic [255:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (ren) rd_pipe[0] <= mem[raddr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rdata = rd_pipe[RL-1];

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    typedef struct {
        logic [9:0]  a;
        int          nb;
        int          beats;
        logic [31:0] lkeep;
        int          first;
        int          lastaddr;
        int          mode;
    } vec_t;

    beat_t      exp_q[$];
    logic [9:0] raddr_log[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int beats_acc = 0;
    int issued = 0;
    int accepted = 0;
    logic [31:0] last_keep_seen = '0;
    int mode = 0;
    int phase = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tready pattern: 0 always on, 1 = 1,0,0,1 repeating, 2 random, 3 off
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            case (mode)
                0: m_tready = 1'b1;
                1: m_tready = (phase % 4 == 0) || (phase % 4 == 3);
                2: m_tready = ($urandom % 4) != 0;
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Monitor: model comparison, stall stability, outstanding reads
    logic         stall_prev = 1'b0;
    logic [288:0] prev_b;
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            exp_q.delete();
            raddr_log.delete();
            issued = 0;
            accepted = 0;
            beats_acc = 0;
            done_cnt = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!m_tvalid || {m_tlast, m_tkeep, m_tdata} !== prev_b) begin
                    errors++;
                    $display("FAIL stall_hold: valid %0b last %0b keep %0h expected held beat", m_tvalid, m_tlast, m_tkeep);
                end
            end
            stall_prev = m_tvalid & ~m_tready;
            prev_b = {m_tlast, m_tkeep, m_tdata};
            if (m_tvalid && m_tready) begin
                accepted++;
                beats_acc++;
                if (m_tlast) last_keep_seen = m_tkeep;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_extra: got keep %0h last %0b expected no beat", m_tkeep, m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
                        errors++;
                        $display("FAIL beat: got keep %0h last %0b data %0h expected keep %0h last %0b data %0h", m_tkeep, m_tlast, m_tdata[63:0], e.keep, e.last, e.data[63:0]);
                    end
                end
            end
            if (ren) begin
                raddr_log.push_back(raddr);
                issued++;
                checks++;
                if (issued - accepted > OD) begin
                    errors++;
                    $display("FAIL outstanding: got %0d expected <= %0d", issued - accepted, OD);
                end
            end
            if (done) done_cnt++;
        end
    end

    // Expected beats from the frame rules: ceil(n/32) words, partial last
    task automatic model_add(input logic [9:0] a, input int nb);
        beat_t b;
        int nw;
        int vb;
        nw = (nb + 31) / 32;
        for (int i = 0; i < nw; i++) begin
            b.data = mem[(int'(a) + i) % 1024];
            b.last = (i == nw - 1);
            vb = b.last ? (nb - 32 * i) : 32;
            for (int k = 0; k < 32; k++) b.keep[k] = (k < vb);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_desc(input logic [9:0] a, input logic [10:0] nb);
        saddr = a;
        sbytes = nb;
        svalid = 1'b1;
        @(posedge clk);
        #1;
        svalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget,
                             input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, done_cnt, target);
    endtask

    task automatic run_row(input vec_t v);
        int d0;
        int b0;
        int r0;
        mode = v.mode;
        d0 = done_cnt;
        b0 = beats_acc;
        r0 = raddr_log.size();
        model_add(v.a, v.nb);
        send_desc(v.a, 11'(v.nb));
        wait_done(d0 + 1, 2000, "row_done");
        chk("row_beats", beats_acc - b0, v.beats);
        chk("row_lkeep", last_keep_seen, v.lkeep);
        chk("row_nreads", raddr_log.size() - r0, v.beats);
        if (raddr_log.size() > r0) begin
            chk("row_first_raddr", raddr_log[r0], v.first);
            chk("row_last_raddr", raddr_log[raddr_log.size() - 1], v.lastaddr);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("row_one_done", done_cnt - d0, 1);
        chk("row_idle", busy, 0);
    endtask

    vec_t vt[6];
    int d0, b0, r0, n, sent;
    logic [9:0] ra;
    int rn;

    initial begin
        vt[0] = '{10'd5,    70,   3,  32'h0000003F, 5,    7,    0};
        vt[1] = '{10'd1022, 96,   3,  32'hFFFFFFFF, 1022, 0,    0};
        vt[2] = '{10'd100,  256,  8,  32'hFFFFFFFF, 100,  107,  1};
        vt[3] = '{10'd40,   1,    1,  32'h00000001, 40,   40,   2};
        vt[4] = '{10'd500,  2047, 64, 32'h7FFFFFFF, 500,  563,  0};
        vt[5] = '{10'd1000, 31,   1,  32'h7FFFFFFF, 1000, 1000, 1};

        for (int i = 0; i < 1024; i++)
            for (int j = 0; j < 8; j++) mem[i][32*j +: 32] = $urandom;
        for (int i = 0; i < RL; i++) rd_pipe[i] = '0;

        svalid = 1'b0;
        saddr = '0;
        sbytes = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata != '0, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_ren", ren, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", desc_overflow, 0);

        for (int i = 0; i < 6; i++) run_row(vt[i]);

        // zero-length followed straight away by a 33-byte frame
        mode = 0;
        d0 = done_cnt;
        b0 = beats_acc;
        r0 = raddr_log.size();
        model_add(10'd20, 33);
        send_desc(10'd10, 11'd0);
        chk("zero_done", done_cnt - d0, 1);
        chk("zero_no_beat", beats_acc - b0, 0);
        send_desc(10'd20, 11'd33);
        wait_done(d0 + 2, 500, "b2b_done");
        chk("b2b_beats", beats_acc - b0, 2);
        chk("b2b_lkeep", last_keep_seen, 32'h00000001);
        chk("b2b_nreads", raddr_log.size() - r0, 2);
        if (raddr_log.size() > r0) chk("b2b_raddr", raddr_log[r0], 20);

        // overflow: one frame stalls in flight, four queue, sixth dropped
        mode = 3;
        d0 = done_cnt;
        b0 = beats_acc;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) model_add(10'(200 + 4 * k), 64);
            send_desc(10'(200 + 4 * k), 11'd64);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("ovf_flag", desc_overflow, 1);
        chk("ovf_busy", busy, 1);
        chk("ovf_no_done", done_cnt - d0, 0);
        mode = 0;
        wait_done(d0 + 5, 500, "ovf_done");
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("ovf_frames", done_cnt - d0, 5);
        chk("ovf_beats", beats_acc - b0, 10);
        chk("ovf_sticky", desc_overflow, 1);
        chk("ovf_model_empty", exp_q.size(), 0);

        // reset during beat 2 of an 8-beat frame
        mode = 0;
        b0 = beats_acc;
        model_add(10'd300, 256);
        send_desc(10'd300, 11'd256);
        n = 0;
        while (!(beats_acc - b0 >= 1 && m_tvalid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_reached_beat2", beats_acc - b0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_tvalid", m_tvalid, 0);
        chk("mid_tdata", m_tdata != '0, 0);
        chk("mid_tkeep", m_tkeep, 0);
        chk("mid_tlast", m_tlast, 0);
        chk("mid_ren", ren, 0);
        chk("mid_done", done, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ovf", desc_overflow, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        b0 = beats_acc;
        r0 = raddr_log.size();
        model_add(10'd600, 100);
        send_desc(10'd600, 11'd100);
        wait_done(d0 + 1, 500, "post_rst_done");
        chk("post_rst_beats", beats_acc - b0, 4);
        chk("post_rst_lkeep", last_keep_seen, 32'h0000000F);
        if (raddr_log.size() > r0) chk("post_rst_raddr", raddr_log[r0], 600);

        // randomized descriptors, never more than three outstanding
        mode = 2;
        d0 = done_cnt;
        sent = 0;
        for (int k = 0; k < 30; k++) begin
            n = 0;
            while ((sent - (done_cnt - d0)) >= 3 && n < 3000) begin
                @(posedge clk);
                #1;
                n++;
            end
            ra = 10'($urandom_range(0, 1023));
            rn = (k % 7 == 0) ? 32 * $urandom_range(1, 4)
                              : $urandom_range(0, 200);
            model_add(ra, rn);
            send_desc(ra, 11'(rn));
            sent++;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_done(d0 + sent, 8000, "rand_done");
        mode = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("rand_frames", done_cnt - d0, sent);
        chk("rand_model_empty", exp_q.size(), 0);
        chk("rand_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
